// File: rtl/mips_mc_controller.sv
// Multicycle control FSM for the 8-bit miniMIPS datapath. It fetches each instruction as
// four byte reads, decodes the opcode, and drives the datapath selects and strobes (Moore).
//
// state   | meaning
// FETCH1-4| byte read n, latch into IR byte n-1, PC += 1
// DECODE  | compute branch target, dispatch on opcode
// MEMADR  | base + imm address for LB/SB
// LBRD    | read data memory at ALU out
// LBWR    | write memdata into rt
// SBWR    | write rd2 to data memory at ALU out
// RTYPEEX | ALU op per funct
// RTYPEWR | write ALU out into rd
// BEQEX   | compare, conditional PC load from ALU out
// JEX     | PC load from jump target
// ADDIEX  | rd1 + imm
// ADDIWR  | write ALU out into rt
module mips_mc_controller #(
  parameter int OPW     = 6,
  parameter bit ILLEGAL = 1'b1
) (
  input  logic           clk_i,
  input  logic           rstb_i,
  input  logic           en_i,
  input  logic [OPW-1:0] op_i,
  input  logic           zero_i,
  output logic           memread_o,
  output logic           memwrite_o,
  output logic           iord_o,
  output logic [3:0]     irwrite_o,
  output logic           pcen_o,
  output logic [1:0]     pcsource_o,
  output logic           alusrca_o,
  output logic [1:0]     alusrcb_o,
  output logic [1:0]     aluop_o,
  output logic           regdst_o,
  output logic           regwrite_o,
  output logic           memtoreg_o,
  output logic           illegal_op_o,
  output logic [3:0]     state_o
);

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14,
    UNUSED  = 4'd15
  } state_t;

  localparam logic [OPW-1:0] OP_LB    = OPW'(6'b100000);
  localparam logic [OPW-1:0] OP_SB    = OPW'(6'b101000);
  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_q   <= FETCH1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    if (en_i) begin
      case (state_q)
        FETCH1:  state_d = FETCH2;
        FETCH2:  state_d = FETCH3;
        FETCH3:  state_d = FETCH4;
        FETCH4:  state_d = DECODE;
        DECODE: begin
          case (op_i)
            OP_LB, OP_SB: state_d = MEMADR;
            OP_RTYPE:     state_d = RTYPEEX;
            OP_BEQ:       state_d = BEQEX;
            OP_J:         state_d = JEX;
            OP_ADDI:      state_d = ADDIEX;
            default: begin
              state_d = FETCH1;
              if (ILLEGAL) illegal_d = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          if (op_i == OP_LB)      state_d = LBRD;
          else if (op_i == OP_SB) state_d = SBWR;
          else                    state_d = FETCH1;
        end
        LBRD:    state_d = LBWR;
        RTYPEEX: state_d = RTYPEWR;
        ADDIEX:  state_d = ADDIWR;
        default: state_d = FETCH1;
      endcase
    end
  end

  // Raw per-state values; strobes are gated below by en and reset.
  logic       mr_raw, mw_raw, rw_raw, pw_raw, pwc_raw;
  logic [3:0] irw_raw;
  logic       iord_raw, asrca_raw, rdst_raw, m2r_raw;
  logic [1:0] psrc_raw, asrcb_raw, aop_raw;

  always_comb begin
    mr_raw    = 1'b0;
    mw_raw    = 1'b0;
    rw_raw    = 1'b0;
    pw_raw    = 1'b0;
    pwc_raw   = 1'b0;
    irw_raw   = 4'b0000;
    iord_raw  = 1'b0;
    asrca_raw = 1'b0;
    rdst_raw  = 1'b0;
    m2r_raw   = 1'b0;
    psrc_raw  = 2'b00;
    asrcb_raw = 2'b00;
    aop_raw   = 2'b00;
    case (state_q)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        mr_raw    = 1'b1;
        irw_raw   = 4'b0001 << state_q[1:0];
        asrcb_raw = 2'b01;
        pw_raw    = 1'b1;
      end
      DECODE: asrcb_raw = 2'b11;
      MEMADR, ADDIEX: begin
        asrca_raw = 1'b1;
        asrcb_raw = 2'b10;
      end
      LBRD: begin
        mr_raw   = 1'b1;
        iord_raw = 1'b1;
      end
      LBWR: begin
        rw_raw  = 1'b1;
        m2r_raw = 1'b1;
      end
      SBWR: begin
        mw_raw   = 1'b1;
        iord_raw = 1'b1;
      end
      RTYPEEX: begin
        asrca_raw = 1'b1;
        aop_raw   = 2'b10;
      end
      RTYPEWR: begin
        rdst_raw = 1'b1;
        rw_raw   = 1'b1;
      end
      BEQEX: begin
        asrca_raw = 1'b1;
        aop_raw   = 2'b01;
        pwc_raw   = 1'b1;
        psrc_raw  = 2'b01;
      end
      JEX: begin
        pw_raw   = 1'b1;
        psrc_raw = 2'b10;
      end
      ADDIWR: rw_raw = 1'b1;
      default: ;
    endcase
  end

  // Strobes drop combinationally when reset is asserted, so an abort leaves no partial write.
  logic strobe_ok;
  assign strobe_ok = en_i & rstb_i;

  assign memread_o  = strobe_ok & mr_raw;
  assign memwrite_o = strobe_ok & mw_raw;
  assign regwrite_o = strobe_ok & rw_raw;
  assign irwrite_o  = strobe_ok ? irw_raw : 4'b0000;
  assign pcen_o     = strobe_ok & (pw_raw | (pwc_raw & zero_i));

  assign iord_o     = rstb_i & iord_raw;
  assign alusrca_o  = rstb_i & asrca_raw;
  assign regdst_o   = rstb_i & rdst_raw;
  assign memtoreg_o = rstb_i & m2r_raw;
  assign pcsource_o = rstb_i ? psrc_raw  : 2'b00;
  assign alusrcb_o  = rstb_i ? asrcb_raw : 2'b00;
  assign aluop_o    = rstb_i ? aop_raw   : 2'b00;

  assign illegal_op_o = illegal_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: directed vector table, hand-written corner sequences,
// then randomized instruction streams checked against a per-instruction state-sequence model.
module tb_mips_mc_controller;

  localparam logic [5:0] LB = 6'b100000, SB = 6'b101000, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       rstb, en, zero;
  logic [5:0] op;
  logic       memread, memwrite, iord, pcen, alusrca, regdst, regwrite, memtoreg, illegal_op;
  logic [3:0] irwrite, state;
  logic [1:0] pcsource, alusrcb, aluop;

  int total = 0;
  int bad   = 0;

  mips_mc_controller #(.OPW(6), .ILLEGAL(1'b1)) dut (
    .clk_i(clk), .rstb_i(rstb), .en_i(en), .op_i(op), .zero_i(zero),
    .memread_o(memread), .memwrite_o(memwrite), .iord_o(iord), .irwrite_o(irwrite),
    .pcen_o(pcen), .pcsource_o(pcsource), .alusrca_o(alusrca), .alusrcb_o(alusrcb),
    .aluop_o(aluop), .regdst_o(regdst), .regwrite_o(regwrite), .memtoreg_o(memtoreg),
    .illegal_op_o(illegal_op), .state_o(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en; logic [5:0] op; logic zero;
    logic [3:0] st; logic [3:0] irw;
    logic pcen, mr, mw, iord, rw, rdst, m2r, ill;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic step(input logic e, input logic [5:0] o, input logic z);
    @(negedge clk);
    en = e; op = o; zero = z;
    #1;
  endtask

  function automatic vec_t mk(input logic e, input logic [5:0] o, input logic z, input int st,
                              input logic [3:0] irw, input logic pc, input logic mr,
                              input logic mw, input logic io, input logic rw,
                              input logic rd, input logic m2, input logic il);
    vec_t v;
    v.en = e; v.op = o; v.zero = z; v.st = 4'(st); v.irw = irw;
    v.pcen = pc; v.mr = mr; v.mw = mw; v.iord = io; v.rw = rw; v.rdst = rd; v.m2r = m2; v.ill = il;
    return v;
  endfunction

  task automatic add_fetch(input logic [5:0] o, input logic il);
    vq.push_back(mk(1, o, 0, 0, 4'b0001, 1, 1, 0, 0, 0, 0, 0, il));
    vq.push_back(mk(1, o, 0, 1, 4'b0010, 1, 1, 0, 0, 0, 0, 0, il));
    vq.push_back(mk(1, o, 0, 2, 4'b0100, 1, 1, 0, 0, 0, 0, 0, il));
    vq.push_back(mk(1, o, 0, 3, 4'b1000, 1, 1, 0, 0, 0, 0, 0, il));
    vq.push_back(mk(1, o, 0, 4, 4'b0000, 0, 0, 0, 0, 0, 0, 0, il));
  endtask

  // Expected outputs from the state table, packed as
  // {memread,memwrite,iord,irwrite[3:0],pcen,pcsource,alusrca,alusrcb,aluop,regdst,regwrite,memtoreg}
  function automatic logic [17:0] exp_out(input int s, input logic z, input logic e);
    logic mr = 0, mw = 0, io = 0, pw = 0, pwc = 0, asa = 0, rd = 0, rw = 0, m2 = 0;
    logic [3:0] irw = 0;
    logic [1:0] ps = 0, asb = 0, ao = 0;
    case (s)
      0, 1, 2, 3: begin mr = 1; irw = 4'(1 << s); asb = 2'b01; pw = 1; end
      4:  asb = 2'b11;
      5:  begin asa = 1; asb = 2'b10; end
      6:  begin mr = 1; io = 1; end
      7:  begin rw = 1; m2 = 1; end
      8:  begin mw = 1; io = 1; end
      9:  begin asa = 1; ao = 2'b10; end
      10: begin rd = 1; rw = 1; end
      11: begin asa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      12: begin pw = 1; ps = 2'b10; end
      13: begin asa = 1; asb = 2'b10; end
      14: rw = 1;
      default: ;
    endcase
    if (!e) begin mr = 0; mw = 0; rw = 0; irw = 0; pw = 0; pwc = 0; end
    return {mr, mw, io, irw, pw | (pwc & z), ps, asa, asb, ao, rd, rw, m2};
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return o == LB || o == SB || o == RT || o == BEQ || o == JMP || o == ADDI;
  endfunction

  int          mq[$];
  logic [5:0]  cur_op;
  logic        model_ill;
  logic [17:0] act;

  initial begin
    // Vector table.
    add_fetch(RT, 0);
    vq.push_back(mk(1, RT, 0, 9,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, RT, 0, 10, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add_fetch(LB, 0);
    vq.push_back(mk(1, LB, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, LB, 0, 6, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, LB, 0, 7, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    add_fetch(SB, 0);
    vq.push_back(mk(1, SB, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, SB, 0, 8, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    add_fetch(ADDI, 0);
    vq.push_back(mk(1, ADDI, 0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, ADDI, 0, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, ADDI, 0, 14, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add_fetch(BEQ, 0);
    vq.push_back(mk(1, BEQ, 1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    add_fetch(BEQ, 0);
    vq.push_back(mk(1, BEQ, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_fetch(JMP, 0);
    vq.push_back(mk(0, JMP, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, JMP, 0, 12, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    add_fetch(6'b111111, 0);
    add_fetch(RT, 1);
    vq.push_back(mk(1, RT, 0, 9,  0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(1, RT, 0, 10, 0, 0, 0, 0, 0, 1, 1, 0, 1));

    // Reset with en=1: strobes must still be held at 0.
    rstb = 1'b0; en = 1'b1; op = RT; zero = 1'b1;
    #13;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_strobes", {memread, memwrite, irwrite, pcen, regwrite}, 32'd0);
    chk("reset_illegal", 32'(illegal_op), 32'd0);
    @(negedge clk);
    en = 1'b0; rstb = 1'b1;

    foreach (vq[i]) begin
      step(vq[i].en, vq[i].op, vq[i].zero);
      chk($sformatf("vec%0d", i),
          {state, irwrite, pcen, memread, memwrite, iord, regwrite, regdst, memtoreg, illegal_op},
          {vq[i].st, vq[i].irw, vq[i].pcen, vq[i].mr, vq[i].mw, vq[i].iord,
           vq[i].rw, vq[i].rdst, vq[i].m2r, vq[i].ill});
    end

    // LB stalled in LBRD for three cycles.
    for (int i = 0; i < 6; i++) begin
      step(1, LB, 0);
      chk("lb_pre_state", 32'(state), 32'(i));
    end
    for (int i = 0; i < 3; i++) begin
      step(0, LB, 0);
      chk("lbrd_stall", {state, memread, iord}, {4'd6, 1'b0, 1'b1});
    end
    step(1, LB, 0);
    chk("lbrd_resume", {state, memread, iord}, {4'd6, 1'b1, 1'b1});
    step(1, LB, 0);
    chk("lbwr_after_stall", {state, regwrite, memtoreg}, {4'd7, 1'b1, 1'b1});

    // Reset asserted mid-cycle in SBWR.
    for (int i = 0; i < 6; i++) step(1, SB, 0);
    step(1, SB, 0);
    chk("sbwr_before_reset", {state, memwrite, illegal_op}, {4'd8, 1'b1, 1'b1});
    #2 rstb = 1'b0;
    #1;
    chk("sbwr_async_reset", {state, memwrite, illegal_op}, {4'd0, 1'b0, 1'b0});
    @(negedge clk);
    en = 1'b0; rstb = 1'b1;

    // Random instruction stream against the sequence model.
    model_ill = 1'b0;
    cur_op = RT;
    for (int n = 0; n < 600; n++) begin
      logic e, z;
      if (mq.size() == 0) begin
        case ($urandom_range(0, 9))
          0: cur_op = LB;   1: cur_op = SB;  2: cur_op = RT;
          3: cur_op = BEQ;  4: cur_op = JMP; 5: cur_op = ADDI;
          6: cur_op = 6'h3F; 7: cur_op = 6'h01; 8: cur_op = 6'h23;
          default: cur_op = 6'h2B;
        endcase
        mq = '{0, 1, 2, 3, 4};
        case (cur_op)
          LB:   begin mq.push_back(5); mq.push_back(6); mq.push_back(7); end
          SB:   begin mq.push_back(5); mq.push_back(8); end
          RT:   begin mq.push_back(9); mq.push_back(10); end
          BEQ:  mq.push_back(11);
          JMP:  mq.push_back(12);
          ADDI: begin mq.push_back(13); mq.push_back(14); end
          default: ;
        endcase
      end
      e = ($urandom_range(0, 4) != 0);
      z = 1'($urandom_range(0, 1));
      step(e, cur_op, z);
      act = {memread, memwrite, iord, irwrite, pcen, pcsource, alusrca, alusrcb, aluop,
             regdst, regwrite, memtoreg};
      chk($sformatf("rnd%0d", n), {state, act, illegal_op},
          {4'(mq[0]), exp_out(mq[0], z, e), model_ill});
      if (e) begin
        if (mq[0] == 4 && !is_legal(cur_op)) model_ill = 1'b1;
        void'(mq.pop_front());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
